md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Sequencing controller for the shared multiply/divide resource in the 5-stage MIPS pipeline.
- Accepts MD ops from the E stage, latches operands and runs a multi-cycle busy countdown (mult vs div latency).
- Commits results to the HI/LO registers and services mthi/mtlo.
- Drives the D-stage stall request that keeps MD instructions out of E while the unit is occupied; that request is ORed into the existing pipeline stall logic.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- E_mdOp  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- E_rsData  in  32  forwarded rs value in E
- E_rtData  in  32  forwarded rt value in E
- D_isMd  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_start  out  1  combinational: E_mdOp in {1..4} and state IDLE
- E_busy  out  1  registered: state BUSY
- E_hi  out  32  HI register
- E_lo  out  32  LO register
- D_mdStall  out  1  combinational: D_isMd & (E_start | E_busy)

Behaviour:
Reset (reset_n=0 at rising edge):
- HI=LO=0, state IDLE, counter=0, E_busy=0.
- Any in-flight op is discarded without commit.

States:
- IDLE -> BUSY on E_start. At that edge:
  - latch the op result into internal pending HI/LO.
  - load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
- BUSY: the counter decrements each edge.
  - At the edge where counter==1: commit pending values to HI/LO, counter->0, state->IDLE.

Latency and visibility:
- E_busy is high for exactly N cycles following the start cycle, with N = the selected parameter.
- New HI/LO are visible in the first cycle E_busy=0.

Arithmetic:
- mult: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
- multu: unsigned 32x32 -> 64, same split.
- div: signed; LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- divu: unsigned quotient/remainder.
- Divide by zero: the op still runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

mthi/mtlo:
- When in IDLE, write E_rsData to HI or LO at the next edge; single cycle, no busy.
- When BUSY, they are ignored.

Illegal and boundary cases:
- Ops 1..6 arriving while BUSY are ignored; no restart, no state change. The stall makes this illegal upstream.
- Same cycle as the commit edge: E_busy is still 1, so a new E op is ignored. A D-stage MD instr stays stalled one more cycle and enters E when busy=0.
- mfhi/mflo read E_hi/E_lo directly; D_mdStall guarantees they never see a stale value.
- D_mdStall is asserted in the start cycle itself (E_start=1), so a back-to-back MD instr in D waits.

Optional Feature:
MD_CANCEL_EN:
- When defined, adds input port E_mdCancel (1 bit).
- E_mdCancel=1 while BUSY forces state->IDLE and counter->0 at the next edge; HI/LO are not committed.
- E_mdCancel=1 in the start cycle suppresses the start: no latch, state stays IDLE.
- mthi/mtlo in the same cycle as E_mdCancel are suppressed.
- Used for exception flush.
- When not defined: no port; every started op completes and commits.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> E_hi=E_lo=0, E_busy=0, D_mdStall=0 with D_isMd=1.
- mult: mult with rs=0xFFFFFFFE (-2), rt=3 -> E_start=1 for 1 cycle, E_busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. With multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div: div with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7/0 -> busy 10 cycles, HI/LO unchanged.
- Stall: D_isMd=1 during the start cycle and all busy cycles -> D_mdStall=1 for 1+N cycles, 0 the cycle after the commit. D_isMd=0 -> D_mdStall=0 throughout.
- mthi/mtlo and ignored ops: mthi 0x12345678 then mtlo 0x9ABCDEF0 in consecutive idle cycles -> HI/LO updated on the following edges. mthi injected while BUSY -> HI unchanged.
- Reset mid-op: reset_n=0 in busy cycle 3 of a div -> E_busy=0, HI=LO=0, no later commit. Under MD_CANCEL_EN, E_mdCancel=1 in busy cycle 2 -> IDLE next cycle, HI/LO keep their prior values.

Source files
------------

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: E/D-stage signal bundle between the MIPS pipeline and the
// multiply/divide sequencer.
//   master : pipeline side (drives op, operands, D_isMd; reads status, HI/LO)
//   slave  : md_unit_ctrl side
// Signals:
//   E_mdOp[2:0]   E-stage MD op (0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none)
//   E_rsData/E_rtData  forwarded operands in E
//   D_isMd        D-stage instruction is an MD instruction
//   E_mdCancel    exception flush (present only when MD_CANCEL_EN is defined)
//   E_start/E_busy/E_hi/E_lo/D_mdStall  unit status and results
interface md_unit_ctrl_if;
    logic [2:0]  E_mdOp;
    logic [31:0] E_rsData;
    logic [31:0] E_rtData;
    logic        D_isMd;
`ifdef MD_CANCEL_EN
    logic        E_mdCancel;
`endif
    logic        E_start;
    logic        E_busy;
    logic [31:0] E_hi;
    logic [31:0] E_lo;
    logic        D_mdStall;

    modport master (
        output E_mdOp, E_rsData, E_rtData, D_isMd,
`ifdef MD_CANCEL_EN
        output E_mdCancel,
`endif
        input  E_start, E_busy, E_hi, E_lo, D_mdStall
    );

    modport slave (
        input  E_mdOp, E_rsData, E_rtData, D_isMd,
`ifdef MD_CANCEL_EN
        input  E_mdCancel,
`endif
        output E_start, E_busy, E_hi, E_lo, D_mdStall
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: sequencing controller for the shared multiply/divide unit.
// An MD op in E starts a fixed-length busy countdown (MULT_CYCLES or
// DIV_CYCLES); the result is computed at start, held pending, and committed
// to HI/LO at the end of the countdown. mthi/mtlo write HI/LO directly when
// idle. D_mdStall holds MD instructions in D while the unit is occupied.
// Ports:
//   clk      pipeline clock
//   reset_n  synchronous active-low reset
//   md       md_unit_ctrl_if.slave (op/operands in, status/HI/LO out)
// Optional feature macro: MD_CANCEL_EN adds md.E_mdCancel (exception flush:
// aborts a busy op without commit, suppresses start and mthi/mtlo).
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset_n,
    md_unit_ctrl_if.slave md
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;   // cleared on divide-by-zero so HI/LO stay put

    logic cancel;
`ifdef MD_CANCEL_EN
    assign cancel = md.E_mdCancel;
`else
    assign cancel = 1'b0;
`endif

    logic is_mul, is_div, idle;
    assign is_mul = (md.E_mdOp == 3'd1) || (md.E_mdOp == 3'd2);
    assign is_div = (md.E_mdOp == 3'd3) || (md.E_mdOp == 3'd4);
    assign idle   = (state == IDLE);

    assign md.E_start   = (is_mul || is_div) && idle && !cancel;
    assign md.E_busy    = (state == BUSY);
    assign md.E_hi      = hi;
    assign md.E_lo      = lo;
    assign md.D_mdStall = md.D_isMd && (md.E_start || md.E_busy);

    // Result datapath, evaluated in the start cycle.
    logic [63:0] smul, umul;
    assign smul = $signed(md.E_rsData) * $signed(md.E_rtData);
    assign umul = {32'd0, md.E_rsData} * {32'd0, md.E_rtData};

    // Divide on magnitudes, then fix signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally
    // (magnitude 0x80000000, negated back to 0x80000000, remainder 0).
    logic        sgn, neg_a, neg_b, div0;
    logic [31:0] mag_a, mag_b, uq, ur, res_q, res_r;
    always_comb begin
        sgn   = (md.E_mdOp == 3'd3);
        neg_a = sgn && md.E_rsData[31];
        neg_b = sgn && md.E_rtData[31];
        mag_a = neg_a ? (32'd0 - md.E_rsData) : md.E_rsData;
        mag_b = neg_b ? (32'd0 - md.E_rtData) : md.E_rtData;
        div0  = (md.E_rtData == 32'd0);
        // Keep the divider defined on zero; the result is discarded anyway.
        if (div0) mag_b = 32'd1;
        uq    = mag_a / mag_b;
        ur    = mag_a % mag_b;
        res_q = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        res_r = neg_a ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.E_start) begin
                        state <= BUSY;
                        if (is_mul) begin
                            cnt     <= 4'(MULT_CYCLES);
                            pend_hi <= (md.E_mdOp == 3'd1) ? smul[63:32] : umul[63:32];
                            pend_lo <= (md.E_mdOp == 3'd1) ? smul[31:0]  : umul[31:0];
                            pend_wr <= 1'b1;
                        end else begin
                            cnt     <= 4'(DIV_CYCLES);
                            pend_hi <= res_r;
                            pend_lo <= res_q;
                            pend_wr <= !div0;
                        end
                    end else if (!cancel && md.E_mdOp == 3'd5) begin
                        hi <= md.E_rsData;
                    end else if (!cancel && md.E_mdOp == 3'd6) begin
                        lo <= md.E_rsData;
                    end
                end
                BUSY: begin
                    // New ops are ignored here; upstream stall keeps them out.
                    if (cancel) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed + randomized self-checking bench for md_unit_ctrl.
// Reference model keeps architectural HI/LO and computes results with 64-bit
// integer arithmetic; timing expectations come from the op latency.
module tb_md_unit_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset_n;
    md_unit_ctrl_if mif();

    md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mif.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of a completed MD op on HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p, sa, sb, q, r;
        longint unsigned up;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd2: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'd3: if (b != 0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (b != 0) begin
                m_lo = a / b; m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    // Run one MD op from start to commit. inj: op injected in busy cycle 2
    // and in the commit cycle (must be ignored); 0 = none.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, input logic [2:0] inj);
        int n;
        n = (op <= 3'd2) ? MULT_N : DIV_N;
        @(posedge clk); #1;
        mif.E_mdOp = op; mif.E_rsData = a; mif.E_rtData = b; mif.D_isMd = dmd;
        @(negedge clk);
        check("start_pulse", 32'(mif.E_start), 32'd1);
        check("start_busy", 32'(mif.E_busy), 32'd0);
        check("start_stall", 32'(mif.D_mdStall), 32'(dmd));
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (inj != 3'd0 && (i == 1 || i == n - 1)) begin
                mif.E_mdOp = inj; mif.E_rsData = $urandom; mif.E_rtData = $urandom;
            end else begin
                mif.E_mdOp = 3'd0;
            end
            @(negedge clk);
            check("busy_hi", 32'(mif.E_busy), 32'd1);
            check("busy_nostart", 32'(mif.E_start), 32'd0);
            check("busy_stall", 32'(mif.D_mdStall), 32'(dmd));
            check("busy_hold_hi", mif.E_hi, m_hi);
        end
        @(posedge clk); #1;
        mif.E_mdOp = 3'd0;
        model(op, a, b);
        @(negedge clk);
        check("done_busy", 32'(mif.E_busy), 32'd0);
        check("done_stall", 32'(mif.D_mdStall), 32'd0);
        check("done_hi", mif.E_hi, m_hi);
        check("done_lo", mif.E_lo, m_lo);
    endtask

    task automatic idle_write(input logic [2:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        mif.E_mdOp = op; mif.E_rsData = v;
        @(negedge clk);
        check("wr_nostart", 32'(mif.E_start), 32'd0);
        @(posedge clk); #1;
        mif.E_mdOp = 3'd0;
        if (op == 3'd5) m_hi = v;
        if (op == 3'd6) m_lo = v;
        @(negedge clk);
        check("wr_hi", mif.E_hi, m_hi);
        check("wr_lo", mif.E_lo, m_lo);
        check("wr_busy", 32'(mif.E_busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset_n = 1'b0;
        mif.E_mdOp = 3'd0; mif.E_rsData = 32'd0; mif.E_rtData = 32'd0; mif.D_isMd = 1'b1;
`ifdef MD_CANCEL_EN
        mif.E_mdCancel = 1'b0;
`endif
        m_hi = 32'd0; m_lo = 32'd0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", mif.E_hi, 32'd0);
        check("rst_lo", mif.E_lo, 32'd0);
        check("rst_busy", 32'(mif.E_busy), 32'd0);
        check("rst_stall", 32'(mif.D_mdStall), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Directed arithmetic and timing
        run_md(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 3'd0);
        check("mult_hi_const", mif.E_hi, 32'hFFFFFFFF);
        check("mult_lo_const", mif.E_lo, 32'hFFFFFFFA);
        run_md(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 3'd0);
        check("multu_hi_const", mif.E_hi, 32'h00000002);
        check("multu_lo_const", mif.E_lo, 32'hFFFFFFFA);
        run_md(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 3'd0);
        check("div_lo_const", mif.E_lo, 32'hFFFFFFFD);
        check("div_hi_const", mif.E_hi, 32'hFFFFFFFF);
        run_md(3'd4, 32'd7, 32'd0, 1'b1, 3'd0);
        check("div0_hi_const", mif.E_hi, 32'hFFFFFFFF);
        check("div0_lo_const", mif.E_lo, 32'hFFFFFFFD);
        run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 3'd0);
        check("ovf_lo_const", mif.E_lo, 32'h80000000);
        check("ovf_hi_const", mif.E_hi, 32'd0);

        // mthi then mtlo in consecutive idle cycles
        @(posedge clk); #1 mif.E_mdOp = 3'd5; mif.E_rsData = 32'h12345678;
        @(posedge clk); #1 mif.E_mdOp = 3'd6; mif.E_rsData = 32'h9ABCDEF0;
        m_hi = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", mif.E_hi, 32'h12345678);
        @(posedge clk); #1 mif.E_mdOp = 3'd0;
        m_lo = 32'h9ABCDEF0;
        @(negedge clk);
        check("mtlo_lo", mif.E_lo, 32'h9ABCDEF0);
        check("mtlo_hi", mif.E_hi, 32'h12345678);

        // Ops injected while busy / on commit edge are ignored
        run_md(3'd1, 32'd1000, 32'd77, 1'b1, 3'd5);
        run_md(3'd4, 32'd12345, 32'd10, 1'b1, 3'd1);

        // Reserved op 7 behaves as none
        @(posedge clk); #1 mif.E_mdOp = 3'd7;
        @(negedge clk);
        check("op7_nostart", 32'(mif.E_start), 32'd0);
        @(posedge clk); #1 mif.E_mdOp = 3'd0;
        @(negedge clk);
        check("op7_busy", 32'(mif.E_busy), 32'd0);
        check("op7_hi", mif.E_hi, m_hi);

`ifdef MD_CANCEL_EN
        // Cancel in busy cycle 2: no commit
        @(posedge clk); #1 mif.E_mdOp = 3'd1; mif.E_rsData = 32'd9; mif.E_rtData = 32'd9;
        @(posedge clk); #1 mif.E_mdOp = 3'd0;
        @(posedge clk); #1 mif.E_mdCancel = 1'b1;
        @(negedge clk);
        check("cxl_busy2", 32'(mif.E_busy), 32'd1);
        @(posedge clk); #1 mif.E_mdCancel = 1'b0;
        @(negedge clk);
        check("cxl_idle", 32'(mif.E_busy), 32'd0);
        repeat (MULT_N) @(posedge clk);
        @(negedge clk);
        check("cxl_hi", mif.E_hi, m_hi);
        check("cxl_lo", mif.E_lo, m_lo);
        // Cancel in start cycle, and with mthi
        @(posedge clk); #1 mif.E_mdOp = 3'd3; mif.E_rtData = 32'd3; mif.E_mdCancel = 1'b1;
        @(negedge clk);
        check("cxl_nostart", 32'(mif.E_start), 32'd0);
        @(posedge clk); #1 mif.E_mdOp = 3'd5; mif.E_rsData = 32'hDEADBEEF;
        @(negedge clk);
        check("cxl_start_idle", 32'(mif.E_busy), 32'd0);
        @(posedge clk); #1 mif.E_mdOp = 3'd0; mif.E_mdCancel = 1'b0;
        @(negedge clk);
        check("cxl_mthi", mif.E_hi, m_hi);
`endif

        // Randomized ops against the model
        for (int k = 0; k < 24; k++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if (op <= 3'd4)
                run_md(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 3'd6 : 3'd0);
            else
                idle_write(op, a);
        end

        // Reset during busy cycle 3 of a div
        @(posedge clk); #1 mif.E_mdOp = 3'd3; mif.E_rsData = 32'd100; mif.E_rtData = 32'd7;
        @(posedge clk); #1 mif.E_mdOp = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        check("rstmid_busy", 32'(mif.E_busy), 32'd0);
        check("rstmid_hi", mif.E_hi, m_hi);
        check("rstmid_lo", mif.E_lo, m_lo);
        repeat (DIV_N + 2) @(posedge clk);
        @(negedge clk);
        check("rstmid_nocommit_hi", mif.E_hi, m_hi);
        check("rstmid_nocommit_lo", mif.E_lo, m_lo);
        check("rstmid_idle", 32'(mif.E_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
